fib_job_dispatcher: RTL

- Upstream job front-end for the fibonacci core.
- Accepts Fibonacci index requests over a valid/ready stream and buffers them in a small FIFO.
- Issues each request to the core as a one-cycle start pulse with din, waits for done, captures dout, and returns {n, value, flags} on a valid/ready response stream.
- Out-of-range indices are screened before they reach the core, and a hung core is covered by a watchdog.

---
 rtl/fib_pkg.sv | 29 ++
 rtl/fib_req_fifo.sv | 62 ++++++
 rtl/fib_job_dispatcher.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// ============================================================================
// fib_pkg : shared types and defaults for the Fibonacci job dispatcher
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package fib_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_MAX_N  = 24;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ARM  = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] n;
    logic [DEF_DATA_W-1:0] value;
    logic                  ovf;
    logic                  err;
  } rsp_t;

endpackage

`default_nettype wire

// File: rtl/fib_req_fifo.sv
// ============================================================================
// fib_req_fifo : synchronous request FIFO, show-ahead head output
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fib_req_fifo
  import fib_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pop,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/fib_job_dispatcher.sv
// ============================================================================
// fib_job_dispatcher : queues index requests, drives the Fibonacci core,
//                      screens out-of-range indices and guards with a watchdog
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fib_job_dispatcher
  import fib_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int FIFO_DEPTH     = 4,
  parameter int MAX_N          = DEF_MAX_N,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_n,
  output logic              core_start,
  output logic [DATA_W-1:0] core_din,
  input  logic [DATA_W-1:0] core_dout,
  input  logic              core_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_n,
  output logic [DATA_W-1:0] rsp_value,
  output logic              rsp_ovf,
  output logic              rsp_err,
  output logic              busy
);

  localparam int              CNT_W   = $clog2(FIFO_DEPTH+1);
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES-1);

  state_t            state;
  logic [DATA_W-1:0] job_n;
  logic [DATA_W-1:0] fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [WD_W-1:0]   wd;
  logic              wd_expired;

  assign req_ready  = !fifo_full;
  assign fifo_pop   = (state == IDLE) && !fifo_empty;
  assign core_start = (state == ISSUE);
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE) || (fifo_count != '0);
  assign wd_expired = (wd == WD_LAST);

  fib_req_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (req_valid && req_ready),
    .din   (req_n),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      job_n     <= '0;
      core_din  <= '0;
      wd        <= '0;
      rsp_n     <= '0;
      rsp_value <= '0;
      rsp_ovf   <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            job_n <= fifo_dout;
            if (fifo_dout > DATA_W'(MAX_N)) begin
              rsp_n     <= fifo_dout;
              rsp_value <= '0;
              rsp_ovf   <= 1'b1;
              rsp_err   <= 1'b0;
              state     <= RESP;
            end else begin
              core_din <= fifo_dout;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wd    <= '0;
          state <= WAIT_ARM;
        end
        // A done level left over from the previous job must drop first.
        WAIT_ARM: begin
          wd <= wd + WD_W'(1);
          if (wd_expired) begin
            rsp_n     <= job_n;
            rsp_value <= '0;
            rsp_ovf   <= 1'b0;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end else if (!core_done) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          wd <= wd + WD_W'(1);
          if (core_done) begin
            rsp_n     <= job_n;
            rsp_value <= core_dout;
            rsp_ovf   <= 1'b0;
            rsp_err   <= 1'b0;
            state     <= RESP;
          end else if (wd_expired) begin
            rsp_n     <= job_n;
            rsp_value <= '0;
            rsp_ovf   <= 1'b0;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
